// File: rtl/ide_pio_host.sv
// Host-side IDE/ATA PIO bus master.
// Turns single-word register read/write requests into timed PIO bus cycles
// (setup, strobe, hold), returns read data and a one-cycle done pulse.
module ide_pio_host #(
  parameter int T_SETUP  = 3,
  parameter int T_ACTIVE = 8,
  parameter int T_HOLD   = 3,
  parameter int CW       = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        wr,
  input  logic [4:0]  addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        busy,
  output logic        done,
  input  logic [15:0] ide_data_in,
  output logic [15:0] ide_data_out,
  output logic        ide_data_oe,
  output logic        ide_dior,
  output logic        ide_diow,
  output logic [1:0]  ide_cs,
  output logic [2:0]  ide_da
);

  typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, HOLD, DONE} state_t;

  // Counter reload values: each phase lasts (load + 1) cycles.
  localparam logic [CW-1:0] SETUP_LD  = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] ACTIVE_LD = CW'(T_ACTIVE - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          wr_q;

  // Bus-cycle FSM; every output is a register so the pins never glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      wr_q         <= 1'b0;
      ide_dior     <= 1'b1;
      ide_diow     <= 1'b1;
      ide_cs       <= 2'b11;
      ide_da       <= 3'd0;
      ide_data_out <= 16'd0;
      ide_data_oe  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      data_out     <= 16'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            // Request fields are captured once; later input changes are ignored.
            wr_q         <= wr;
            ide_cs       <= addr[4:3];
            ide_da       <= addr[2:0];
            ide_data_out <= wr ? data_in : 16'd0;
            ide_data_oe  <= wr;
            busy         <= 1'b1;
            cnt          <= SETUP_LD;
            state        <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            if (wr_q) ide_diow <= 1'b0;
            else      ide_dior <= 1'b0;
            cnt   <= ACTIVE_LD;
            state <= ACTIVE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ACTIVE: begin
          if (cnt == '0) begin
            // Read data is taken on the edge that ends the strobe.
            if (!wr_q) data_out <= ide_data_in;
            ide_dior <= 1'b1;
            ide_diow <= 1'b1;
            cnt      <= HOLD_LD;
            state    <= HOLD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            done         <= 1'b1;
            busy         <= 1'b0;
            ide_cs       <= 2'b11;
            ide_da       <= 3'd0;
            ide_data_out <= 16'd0;
            ide_data_oe  <= 1'b0;
            state        <= DONE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DONE: begin
          // A request arriving here is dropped, not queued.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ide_pio_host.sv
// Bench for ide_pio_host: default-timing instance plus a 1/1/1-timing instance.
module tb_ide_pio_host;

  localparam int TS = 3, TA = 8, TH = 3;
  localparam int DONE_C = TS + TA + TH + 1;

  logic        clk = 1'b0;
  logic        reset_n;

  // default-timing DUT
  logic        req, wr;
  logic [4:0]  addr;
  logic [15:0] data_in, data_out, ide_data_in, ide_data_out;
  logic        busy, done, ide_data_oe, ide_dior, ide_diow;
  logic [1:0]  ide_cs;
  logic [2:0]  ide_da;

  // minimum-timing DUT
  logic        req1, wr1;
  logic [4:0]  addr1;
  logic [15:0] data_in1, data_out1, ide_data_in1, ide_data_out1;
  logic        busy1, done1, ide_data_oe1, ide_dior1, ide_diow1;
  logic [1:0]  ide_cs1;
  logic [2:0]  ide_da1;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp1_q[$];
  logic [15:0] model_dout;

  always #5 clk = ~clk;

  ide_pio_host dut (
    .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .busy(busy), .done(done),
    .ide_data_in(ide_data_in), .ide_data_out(ide_data_out),
    .ide_data_oe(ide_data_oe), .ide_dior(ide_dior), .ide_diow(ide_diow),
    .ide_cs(ide_cs), .ide_da(ide_da)
  );

  ide_pio_host #(.T_SETUP(1), .T_ACTIVE(1), .T_HOLD(1), .CW(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req1), .wr(wr1), .addr(addr1),
    .data_in(data_in1), .data_out(data_out1), .busy(busy1), .done(done1),
    .ide_data_in(ide_data_in1), .ide_data_out(ide_data_out1),
    .ide_data_oe(ide_data_oe1), .ide_dior(ide_dior1), .ide_diow(ide_diow1),
    .ide_cs(ide_cs1), .ide_da(ide_da1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // One transaction on the default DUT; called at a negedge with the DUT idle.
  task automatic run_txn(input logic w, input logic [4:0] a, input logic [15:0] d,
                         input logic [15:0] di);
    logic got_done;
    logic [15:0] want;
    req = 1'b1; wr = w; addr = a; data_in = d; ide_data_in = di;
    exp_q.push_back(w ? model_dout : di);
    if (!w) model_dout = di;
    got_done = 1'b0;
    for (int n = 1; n <= DONE_C + 5 && !got_done; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req = 1'b0; wr = ~w; addr = ~a; data_in = ~d;
      end
      check("dior", ide_dior, (!w && n >= TS + 1 && n <= TS + TA) ? 1'b0 : 1'b1);
      check("diow", ide_diow, ( w && n >= TS + 1 && n <= TS + TA) ? 1'b0 : 1'b1);
      if (n < DONE_C) begin
        check("cs", ide_cs, a[4:3]);
        check("da", ide_da, a[2:0]);
        check("oe", ide_data_oe, w);
        check("wdata", ide_data_out, w ? d : 16'd0);
        check("busy", busy, 1'b1);
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        check("done_cycle", n, DONE_C);
        check("busy_at_done", busy, 1'b0);
        check("cs_at_done", ide_cs, 2'b11);
        check("oe_at_done", ide_data_oe, 1'b0);
        if (exp_q.size() == 0) check("sb_empty", 1, 0);
        else begin
          want = exp_q.pop_front();
          check("data_out", data_out, want);
        end
      end
    end
    if (!got_done) check("done_seen", 0, 1);
    @(negedge clk);
    check("done_cleared", done, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [4:0] good [3];
    logic [4:0] cur;
    logic [15:0] want;
    good[0] = 5'b01_011; good[1] = 5'b10_101; good[2] = 5'b11_110;
    reset_n = 1'b0;
    req = 0; wr = 0; addr = 0; data_in = 0; ide_data_in = 0;
    req1 = 0; wr1 = 0; addr1 = 0; data_in1 = 0; ide_data_in1 = 0;
    model_dout = 16'd0;
    cur = '0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_dior", ide_dior, 1'b1);
    check("rst_diow", ide_diow, 1'b1);
    check("rst_cs", ide_cs, 2'b11);
    check("rst_da", ide_da, 3'd0);
    check("rst_oe", ide_data_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dout", data_out, 16'd0);
    check("rst1_dior", ide_dior1, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);

    // read then write
    run_txn(1'b0, 5'b10_111, 16'h0000, 16'h0050);
    run_txn(1'b1, 5'b10_000, 16'hBEEF, 16'hDEAD);

    // req held high: accepted at 0, 16, 32 with scrambled inputs in between
    ndone = 0;
    for (int i = 0; i < 48; i++) begin
      req = 1'b1;
      ide_data_in = 16'h1000 + 16'(i);
      if (i % 16 == 0) begin
        cur = good[i / 16];
        addr = cur; wr = 1'b0; data_in = 16'h0000;
        exp_q.push_back(16'h1000 + 16'(i + TS + TA - 1 + 1));
      end else begin
        addr = 5'($urandom); wr = 1'($urandom); data_in = 16'($urandom);
      end
      @(negedge clk);
      if ((i + 1) % 16 >= 1 && (i + 1) % 16 <= 14) begin
        check("held_cs", ide_cs, cur[4:3]);
        check("held_da", ide_da, cur[2:0]);
        check("held_diow", ide_diow, 1'b1);
        check("held_dior", ide_dior,
              ((i + 1) % 16 >= TS + 1 && (i + 1) % 16 <= TS + TA) ? 1'b0 : 1'b1);
      end else if ((i + 1) % 16 == 15) begin
        check("held_done", done, 1'b1);
        if (exp_q.size() == 0) check("held_sb_empty", 1, 0);
        else begin
          want = exp_q.pop_front();
          check("held_data", data_out, want);
          model_dout = want;
        end
      end else begin
        check("held_idle_busy", busy, 1'b0);
      end
      if (done === 1'b1) ndone++;
    end
    req = 1'b0;
    check("held_done_count", ndone, 3);

    // reset during ACTIVE of a read
    req = 1'b1; wr = 1'b0; addr = 5'b10_001; ide_data_in = 16'h7777;
    exp_q.push_back(16'h7777);
    @(negedge clk);
    req = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_dior", ide_dior, 1'b0);
    reset_n = 1'b0;
    #1;
    check("arst_dior", ide_dior, 1'b1);
    check("arst_cs", ide_cs, 2'b11);
    check("arst_busy", busy, 1'b0);
    check("arst_dout", data_out, 16'd0);
    exp_q.delete();
    model_dout = 16'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("arst_no_done", ndone, 0);
    check("arst_dout_after", data_out, 16'd0);
    run_txn(1'b0, 5'b01_100, 16'h0000, 16'h1234);

    // minimum timing: read, data bus changed right after the sampling edge
    req1 = 1'b1; wr1 = 1'b0; addr1 = 5'b01_010; ide_data_in1 = 16'hA5A5;
    exp1_q.push_back(16'hA5A5);
    ndone = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      req1 = 1'b0;
      if (n == 3) ide_data_in1 = 16'h0F0F;
      check("min_dior", ide_dior1, (n == 2) ? 1'b0 : 1'b1);
      check("min_diow", ide_diow1, 1'b1);
      check("min_done", done1, (n == 4) ? 1'b1 : 1'b0);
      if (done1 === 1'b1) begin
        ndone++;
        if (exp1_q.size() == 0) check("min_sb_empty", 1, 0);
        else begin
          want = exp1_q.pop_front();
          check("min_data", data_out1, want);
        end
      end
    end
    check("min_done_count", ndone, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ide_pio_host.md
Name: ide_pio_host

Overview:
- Host-side IDE/ATA PIO bus master: the initiator that drives the disk interface (`ide_cs`/`ide_da`/`ide_dior`/`ide_diow`) toward a drive model or real drive.
- Converts single-word register read/write requests from the disk controller into timed PIO bus cycles (setup, strobe, hold).
- Returns read data and a one-cycle completion pulse.
- Sits between the disk controller logic and the IDE pins or drive-model wrapper in simulation.

Parameters:
- T_SETUP, 3, clk cycles address/cs valid before strobe asserts (must be >=1)
- T_ACTIVE, 8, clk cycles dior/diow held low (must be >=1)
- T_HOLD, 3, clk cycles address/cs/write-data held after strobe deasserts (must be >=1)
- CW, 4, timing counter width; must hold max(T_SETUP,T_ACTIVE,T_HOLD)-1

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  1  request strobe, sampled only when busy=0
- wr  in  1  1=write, 0=read; sampled with req
- addr  in  5  {cs[1:0], da[2:0]}; cs is active-low, driven verbatim during the cycle
- data_in  in  16  write data; sampled with req
- data_out  out  16  read data; valid from done onward until next read completes
- busy  out  1  high from accept through HOLD
- done  out  1  one-cycle completion pulse
- ide_data_in  in  16  data from drive
- ide_data_out  out  16  data to drive
- ide_data_oe  out  1  host drives data bus
- ide_dior  out  1  read strobe, active-low
- ide_diow  out  1  write strobe, active-low
- ide_cs  out  2  chip selects, active-low
- ide_da  out  3  register address

Behaviour:
- Reset values (asynchronous, also mid-operation):
  - state=IDLE
  - ide_dior=1, ide_diow=1, ide_cs=2'b11, ide_da=0
  - ide_data_out=0, ide_data_oe=0
  - busy=0, done=0, data_out=0
  - any in-flight cycle is abandoned with no done pulse
- All outputs are registered. FSM states: IDLE, SETUP, ACTIVE, HOLD, DONE.
- IDLE:
  - If req=1 at edge E0, latch wr/addr/data_in, load counter with T_SETUP-1, and go to SETUP.
  - From E0, ide_cs=addr[4:3], ide_da=addr[2:0], busy=1.
  - For writes, ide_data_out=data_in and ide_data_oe=1.
- SETUP: strobes high. When counter=0, go to ACTIVE and load T_ACTIVE-1; otherwise decrement.
- ACTIVE:
  - ide_dior=0 (read) or ide_diow=0 (write).
  - When counter=0: latch data_out<=ide_data_in (read only), deassert the strobe, go to HOLD, and load T_HOLD-1.
  - data_out is therefore ide_data_in as sampled on the edge ending the last ACTIVE cycle.
- HOLD: strobes high; cs/da/ide_data_out/ide_data_oe unchanged. When counter=0, go to DONE.
- DONE (one cycle):
  - done=1, busy=0.
  - ide_cs=2'b11, ide_da=0, ide_data_oe=0, ide_data_out=0.
  - Next state IDLE. A req seen in DONE is ignored.
- Cycle timing relative to E0:
  - SETUP occupies cycles 1..T_SETUP.
  - ACTIVE occupies T_SETUP+1..T_SETUP+T_ACTIVE.
  - HOLD follows.
  - done is high in cycle T_SETUP+T_ACTIVE+T_HOLD+1 (15 with defaults).
  - Minimum req-to-req spacing is that value +1.
- req while busy=1 or in DONE: ignored, never queued. Changes to wr/addr/data_in after acceptance have no effect.
- Writes leave data_out unchanged.
- ide_dior and ide_diow are never both low; exactly one strobe is low only in ACTIVE.
- addr cs=2'b11 is not rejected: the cycle runs with no chip select asserted.

Test Plan:
- Reset, defaults → all strobes 1, ide_cs=11, busy=0, done=0, data_out=0.
- Read addr=5'b10_111, ide_data_in=16'h0050:
  - ide_cs=10 and ide_da=7 from cycle 1.
  - ide_dior=0 exactly cycles 4..11.
  - done=1 at cycle 15, data_out=16'h0050.
- Write addr=5'b10_000, data_in=16'hBEEF:
  - ide_data_oe=1 and ide_data_out=BEEF for cycles 1..14.
  - ide_diow=0 exactly cycles 4..11, ide_dior stays 1.
  - done at 15; data_out keeps its prior value.
- req held high continuously:
  - Cycles accepted at 0, 16, 32.
  - Exactly one done per cycle.
  - Mid-cycle changes to addr/data_in are not reflected on the bus.
- reset_n pulsed low during ACTIVE of a read:
  - ide_dior=1 and ide_cs=11 immediately (asynchronous).
  - No done pulse; data_out=0.
  - The next req runs a normal full cycle.
- Parameters T_SETUP=1, T_ACTIVE=1, T_HOLD=1:
  - Strobe low for exactly cycle 2.
  - done at cycle 4.
  - Read data sampled correctly.
